// File: rtl/dec_syndrome_calc.sv
// dec_syndrome_calc: folds a SECDED codeword chunk-wise into syndrome/parity and classifies it.
// rst is asynchronous and active-low.
module dec_syndrome_calc #(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] codeword_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] codeword,
  output logic                  areThereErrors,
  output logic                  isThereOneError,
  output logic [4:0]            whichColIsError
);
  localparam int NBEATS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int BW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, HOLD = 2'd2;
  logic [1:0] state;
  logic [BW-1:0] beat_cnt;
  logic [DATA_WIDTH-1:0] data;
  logic [NBEATS-1:0][CHUNK_WIDTH-1:0] chunks;
  logic [CHUNK_WIDTH-1:0] chunk;
  logic [4:0] s, s_nxt, base;
  logic p, p_nxt, last, accept;
  assign chunks = data;
  assign chunk = chunks[beat_cnt];
  assign base = 5'(beat_cnt) * 5'(CHUNK_WIDTH);
  assign last = beat_cnt == BW'(NBEATS - 1);
  assign in_ready = state == IDLE || (state == HOLD && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state == HOLD;
  always_comb begin
    s_nxt = s;
    p_nxt = p;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      s_nxt = chunk[i] ? s_nxt ^ (base + 5'(i)) : s_nxt;
      p_nxt = p_nxt ^ chunk[i];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= IDLE;
      beat_cnt        <= '0;
      data            <= '0;
      s               <= '0;
      p               <= 1'b0;
      codeword        <= '0;
      areThereErrors  <= 1'b0;
      isThereOneError <= 1'b0;
      whichColIsError <= '0;
    end else if (accept) begin
      data     <= codeword_in;
      s        <= '0;
      p        <= 1'b0;
      beat_cnt <= '0;
      state    <= CALC;
    end else if (state == HOLD && out_ready) begin
      state <= IDLE;
    end else if (state == CALC) begin
      s        <= s_nxt;
      p        <= p_nxt;
      beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      if (last) begin
        state           <= HOLD;
        codeword        <= data;
        areThereErrors  <= s_nxt == 5'd0 && !p_nxt;
        isThereOneError <= p_nxt;
        whichColIsError <= s_nxt;
      end
    end
endmodule

// File: tb/tb_dec_syndrome_calc.sv
// tb_dec_syndrome_calc: table-driven check of 16/8 and 32/4 syndrome instances.
module tb_dec_syndrome_calc;
  typedef struct {
    logic        sel;
    logic [31:0] cw;
    logic        ae;
    logic        one;
    logic [4:0]  col;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sel = 1'b0;
  logic [31:0] codeword_in = '0;
  logic in_ready_a, ov_a, ae_a, one_a, in_ready_b, ov_b, ae_b, one_b;
  logic [15:0] cw_a;
  logic [31:0] cw_b;
  logic [4:0] col_a, col_b;
  logic ir, ov, ae, one;
  logic [4:0] col;
  logic [31:0] cw;
  int nb;
  int tests = 0, fails = 0;
  vec_t v[15];

  always #5 clk = ~clk;

  dec_syndrome_calc #(.DATA_WIDTH(16), .CHUNK_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready_a),
    .codeword_in(codeword_in[15:0]), .out_valid(ov_a), .out_ready(out_ready),
    .codeword(cw_a), .areThereErrors(ae_a), .isThereOneError(one_a), .whichColIsError(col_a));
  dec_syndrome_calc #(.DATA_WIDTH(32), .CHUNK_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready_b),
    .codeword_in(codeword_in), .out_valid(ov_b), .out_ready(out_ready),
    .codeword(cw_b), .areThereErrors(ae_b), .isThereOneError(one_b), .whichColIsError(col_b));

  assign ir  = sel ? in_ready_b : in_ready_a;
  assign ov  = sel ? ov_b : ov_a;
  assign ae  = sel ? ae_b : ae_a;
  assign one = sel ? one_b : one_a;
  assign col = sel ? col_b : col_a;
  assign cw  = sel ? cw_b : {16'h0, cw_a};
  assign nb  = sel ? 8 : 2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!ov && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, " latency"}, n, nb);
  endtask

  task automatic chk_vec(input int k);
    chk($sformatf("ae[%0d]", k), ae, v[k].ae);
    chk($sformatf("one[%0d]", k), one, v[k].one);
    chk($sformatf("col[%0d]", k), col, v[k].col);
    chk($sformatf("cw[%0d]", k), cw, v[k].cw);
  endtask

  task automatic run_one(input int k, input bit drain);
    sel = v[k].sel;
    codeword_in = v[k].cw;
    in_valid = 1'b1;
    #1 chk($sformatf("in_ready[%0d]", k), ir, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result($sformatf("vec%0d", k));
    chk_vec(k);
    if (drain) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk($sformatf("drain[%0d]", k), ov, 0);
    end
  endtask

  task automatic stream(input int ks[3]);
    int ni = 0, no = 0, cyc = 0;
    int acc[3];
    sel = v[ks[0]].sel;
    out_ready = 1'b1;
    while (no < 3 && cyc < 100) begin
      if (ni < 3) begin
        in_valid = 1'b1;
        codeword_in = v[ks[ni]].cw;
      end else in_valid = 1'b0;
      #1;
      if (ov) begin
        chk($sformatf("stream latency[%0d]", ks[no]), cyc - acc[no], nb + 1);
        chk_vec(ks[no]);
        no++;
      end
      if (in_valid && ir) begin
        acc[ni] = cyc;
        ni++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream count", no, 3);
  endtask

  initial begin
    logic [31:0] snap_cw;
    logic [4:0] snap_col;
    logic snap_ae, snap_one, seen;
    v[0]  = '{1'b0, 32'h0000,      1'b1, 1'b0, 5'd0};
    v[1]  = '{1'b0, 32'h0020,      1'b0, 1'b1, 5'd5};
    v[2]  = '{1'b0, 32'h0001,      1'b0, 1'b1, 5'd0};
    v[3]  = '{1'b0, 32'h0007,      1'b0, 1'b1, 5'd3};
    v[4]  = '{1'b0, 32'h0006,      1'b0, 1'b0, 5'd3};
    v[5]  = '{1'b0, 32'h8000,      1'b0, 1'b1, 5'd15};
    v[6]  = '{1'b0, 32'hFFFF,      1'b1, 1'b0, 5'd0};
    v[7]  = '{1'b0, 32'h0300,      1'b0, 1'b0, 5'd1};
    v[8]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 5'd31};
    v[9]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 5'd0};
    v[10] = '{1'b1, 32'h0000_0006, 1'b0, 1'b0, 5'd3};
    v[11] = '{1'b1, 32'h0001_0001, 1'b0, 1'b0, 5'd16};
    v[12] = '{1'b1, 32'h0003_0000, 1'b0, 1'b0, 5'd1};
    v[13] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0};
    v[14] = '{1'b1, 32'h8000_0001, 1'b0, 1'b0, 5'd31};
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", ov, 0);
    chk("rst in_ready", ir, 1);
    chk("rst ae", ae, 0);
    chk("rst one", one, 0);
    chk("rst col", col, 0);
    chk("rst cw", cw, 0);
    rst = 1'b1;
    for (int k = 0; k < 15; k++) run_one(k, 1'b1);
    // stall in HOLD, then a release pulse that also accepts the next word
    run_one(3, 1'b0);
    snap_cw = cw; snap_ae = ae; snap_one = one; snap_col = col;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("stall ov", ov, 1);
      chk("stall in_ready", ir, 0);
      chk("stall cw", cw, snap_cw);
      chk("stall col", {snap_ae, snap_one, col}, {ae, one, snap_col});
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    codeword_in = 32'h0020;
    #1 chk("release in_ready", ir, 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    chk("release ov", ov, 0);
    wait_result("post-stall");
    chk_vec(1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    stream('{1, 4, 0});
    stream('{8, 10, 9});
    // reset mid-CALC after a nonzero result is held
    run_one(8, 1'b1);
    sel = 1'b1;
    codeword_in = 32'h3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst ov", ov, 0);
    chk("midrst in_ready", ir, 1);
    chk("midrst col", col, 0);
    chk("midrst one", one, 0);
    chk("midrst cw", cw, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen = seen | ov;
    end
    chk("dropped word ov", seen, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
